// File: rtl/pipemdu_if.sv
// Execute-stage MDU bus: operands/opcode/read selects in, HI/LO, result and stall out.
// Latency: none, wires only. Backpressure: estall returned to the pipeline hazard logic.
// master = pipeline side, slave = the multiply/divide unit.
interface pipemdu_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] eb;
    logic [2:0]      emduop;
    logic            emfhi;
    logic            emflo;
    logic [XLEN-1:0] emdu_out;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            busy;
    logic            estall;

    modport master (
        output ea, eb, emduop, emfhi, emflo,
        input  emdu_out, hi, lo, busy, estall
    );

    modport slave (
        input  ea, eb, emduop, emfhi, emflo,
        output emdu_out, hi, lo, busy, estall
    );
endinterface

// File: rtl/pipemdu.sv
// Radix-2 iterative multiply/divide unit owning HI/LO for the execute stage.
// Latency: XLEN+1 edges from issue to HI/LO written (XLEN iterations plus a sign-fix edge).
// Backpressure: estall asserted while busy and the E-stage op needs the MDU or HI/LO.
module pipemdu #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     clrn,
    pipemdu_if.slave mdu
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]   count;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] m;
    logic [XLEN-1:0] hi_r;
    logic [XLEN-1:0] lo_r;
    logic            is_div;
    logic            neg_res;
    logic            neg_rem;
    logic            div_zero;

    logic            op_vld;
    logic            op_div;
    logic            op_signed;
    logic            start;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

    always_comb begin
        op_vld    = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        case (mdu.emduop)
            3'b001: begin op_vld = 1'b1; op_signed = 1'b1; end
            3'b010: begin op_vld = 1'b1; end
            3'b011: begin op_vld = 1'b1; op_div = 1'b1; op_signed = 1'b1; end
            3'b100: begin op_vld = 1'b1; op_div = 1'b1; end
            default: ;
        endcase
    end

    assign start  = (state == IDLE) && op_vld;
    assign sign_a = op_signed & mdu.ea[XLEN-1];
    assign sign_b = op_signed & mdu.eb[XLEN-1];
    assign abs_a  = sign_a ? -mdu.ea : mdu.ea;
    assign abs_b  = sign_b ? -mdu.eb : mdu.eb;

    // Multiply: acc:q is the running product, q starts as the multiplier.
    // Divide: acc is the partial remainder, q shifts the dividend out and quotient in.
    // Since acc < m every step, the XLEN-bit remainder never overflows.
    assign mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    assign div_shift = {acc, q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, m};

    always_comb begin
        prod     = {acc, q};
        prod_fix = neg_res ? -prod : prod;
        fix_hi   = prod_fix[2*XLEN-1:XLEN];
        fix_lo   = prod_fix[XLEN-1:0];
        if (is_div) begin
            // Zero divisor leaves the dividend magnitude in acc; neg_rem restores its sign.
            fix_hi = neg_rem ? -acc : acc;
            fix_lo = div_zero ? '1 : (neg_res ? -q : q);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count    <= '0;
            acc      <= '0;
            q        <= '0;
            m        <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= CW'(XLEN);
                        acc      <= '0;
                        q        <= op_div ? abs_a : abs_b;
                        m        <= op_div ? abs_b : abs_a;
                        is_div   <= op_div;
                        neg_res  <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
                        div_zero <= op_div && (mdu.eb == '0);
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (is_div) begin
                        if (!div_diff[XLEN]) begin
                            acc <= div_diff[XLEN-1:0];
                            q   <= {q[XLEN-2:0], 1'b1};
                        end else begin
                            acc <= div_shift[XLEN-1:0];
                            q   <= {q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum[XLEN:1];
                        q   <= {mul_sum[0], q[XLEN-1:1]};
                    end
                end
                FIX: begin
                    hi_r <= fix_hi;
                    lo_r <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign mdu.busy     = (state != IDLE);
    assign mdu.estall   = mdu.busy & (op_vld | mdu.emfhi | mdu.emflo);
    assign mdu.hi       = hi_r;
    assign mdu.lo       = lo_r;
    assign mdu.emdu_out = mdu.emfhi ? hi_r : (mdu.emflo ? lo_r : '0);
endmodule
